// File: rtl/pin_button_reader.sv
// pin_button_reader
// Synchronizes and debounces the raw pushbutton pin, classifies each accepted
// press as short or long, and shows a 4-bit press count on the LED pins.
// Everything runs in the pG0 domain; pG1 is an asynchronous active-high reset.

module pin_button_reader #(
  parameter int DB_BITS    = 10,
  parameter int LONG_BITS  = 14,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic pG0,
  input  logic pG1,
  input  logic p3B2,
  output logic p3A0,
  output logic p3A1,
  output logic p3A2,
  output logic p3A3,
  output logic press_pulse,
  output logic long_pulse,
  output logic held
);

  // Pin level when the button is released; the synchronizer resets to it so
  // that reset never looks like a press.
  localparam logic INACTIVE_LVL = ACTIVE_LOW;

  localparam logic [DB_BITS-1:0]   DB_MAX    = {DB_BITS{1'b1}};
  localparam logic [DB_BITS-1:0]   DB_ZERO   = {DB_BITS{1'b0}};
  localparam logic [DB_BITS-1:0]   DB_ONE    = DB_BITS'(1'b1);
  localparam logic [LONG_BITS-1:0] HOLD_MAX  = {LONG_BITS{1'b1}};
  localparam logic [LONG_BITS-1:0] HOLD_ZERO = {LONG_BITS{1'b0}};
  localparam logic [LONG_BITS-1:0] HOLD_ONE  = LONG_BITS'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Two-flop synchronizer; nothing else looks at p3B2.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Debouncer: accepted level plus run length of differing samples.
  logic               stable_q, stable_d;
  logic [DB_BITS-1:0] db_ctr_q, db_ctr_d;

  // Press classifier and registered outputs.
  state_t               state_q, state_d;
  logic [LONG_BITS-1:0] hold_ctr_q, hold_ctr_d;
  logic [3:0]           count_q, count_d;
  logic                 press_q, press_d;
  logic                 long_q, long_d;
  logic                 held_q, held_d;

  // Polarity-normalized synchronized button: 1 means pressed.
  logic btn_s;

  assign btn_s = sync2_q ^ ACTIVE_LOW;

  // Synchronizer next state: shift the raw pin through two stages.
  always_comb begin
    sync1_d = p3B2;
    sync2_d = sync1_q;
  end

  // Debounce: a new level is accepted only after a full window of differing
  // samples; any agreeing sample restarts the window.
  always_comb begin
    stable_d = stable_q;
    db_ctr_d = db_ctr_q;
    if (btn_s == stable_q) begin
      db_ctr_d = DB_ZERO;
    end else if (db_ctr_q != DB_MAX) begin
      db_ctr_d = db_ctr_q + DB_ONE;
    end else begin
      stable_d = btn_s;
      db_ctr_d = DB_ZERO;
    end
  end

  // Press classifier: counts presses, times the hold, raises strobes.
  // A release seen on the cycle the hold timer expires wins over the long strobe.
  always_comb begin
    state_d    = state_q;
    hold_ctr_d = hold_ctr_q;
    count_d    = count_q;
    press_d    = 1'b0;
    long_d     = 1'b0;
    held_d     = held_q;
    case (state_q)
      ST_IDLE: begin
        if (stable_q) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          count_d    = count_q + 4'd1;
          hold_ctr_d = HOLD_ZERO;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (!stable_q) begin
          state_d    = ST_IDLE;
        end else if (hold_ctr_q == HOLD_MAX) begin
          state_d    = ST_HELD;
          long_d     = 1'b1;
          held_d     = 1'b1;
        end else begin
          hold_ctr_d = hold_ctr_q + HOLD_ONE;
        end
      end
      ST_HELD: begin
        if (!stable_q) begin
          state_d    = ST_IDLE;
          held_d     = 1'b0;
        end else begin
          state_d    = ST_HELD;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_ctr_d = HOLD_ZERO;
        held_d     = 1'b0;
      end
    endcase
  end

  // State register for the whole block; pG1 clears it without a clock.
  always_ff @(posedge pG0 or posedge pG1) begin
    if (pG1) begin
      sync1_q    <= INACTIVE_LVL;
      sync2_q    <= INACTIVE_LVL;
      stable_q   <= 1'b0;
      db_ctr_q   <= DB_ZERO;
      state_q    <= ST_IDLE;
      hold_ctr_q <= HOLD_ZERO;
      count_q    <= 4'd0;
      press_q    <= 1'b0;
      long_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      db_ctr_q   <= db_ctr_d;
      state_q    <= state_d;
      hold_ctr_q <= hold_ctr_d;
      count_q    <= count_d;
      press_q    <= press_d;
      long_q     <= long_d;
      held_q     <= held_d;
    end
  end

  assign p3A0        = count_q[0];
  assign p3A1        = count_q[1];
  assign p3A2        = count_q[2];
  assign p3A3        = count_q[3];
  assign press_pulse = press_q;
  assign long_pulse  = long_q;
  assign held        = held_q;

endmodule

// File: tb/tb_pin_button_reader.sv
// Self-checking bench for pin_button_reader (DB_BITS=2, LONG_BITS=3, active-low pin).
// Stimulus feeds a run-length reference model that predicts the cycle of every
// press / long / held-release event; a monitor compares DUT strobes against it.

module tb_pin_button_reader;

  localparam int DB_BITS   = 2;
  localparam int LONG_BITS = 3;
  localparam int DB_WIN    = 1 << DB_BITS;
  localparam int LONG_WIN  = 1 << LONG_BITS;

  localparam int K_NONE  = 0;
  localparam int K_PRESS = 1;
  localparam int K_LONG  = 2;
  localparam int K_FALL  = 3;
  localparam int K_BOTH  = 4;

  typedef struct {
    int kind;
    int edge_no;
    int cnt;
  } ev_t;

  logic pG0, pG1, p3B2;
  logic p3A0, p3A1, p3A2, p3A3;
  logic press_pulse, long_pulse, held;

  pin_button_reader #(
    .DB_BITS   (DB_BITS),
    .LONG_BITS (LONG_BITS),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .pG0        (pG0),
    .pG1        (pG1),
    .p3B2       (p3B2),
    .p3A0       (p3A0),
    .p3A1       (p3A1),
    .p3A2       (p3A2),
    .p3A3       (p3A3),
    .press_pulse(press_pulse),
    .long_pulse (long_pulse),
    .held       (held)
  );

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int press_seen = 0;

  ev_t sb_q[$];

  // Reference model state (accepted level, differing-run length, bookkeeping).
  bit m_stable;
  int m_run;
  int m_count;
  bit m_long_pend;
  int m_long_at;
  bit m_held;

  // Monitor-side expectations.
  int exp_count = 0;
  bit held_prev = 1'b0;

  initial pG0 = 1'b0;
  always #5 pG0 = ~pG0;

  // Absolute posedge counter; a sample driven before posedge N is captured on edge N.
  always @(posedge pG0) cyc <= cyc + 1;

  function automatic logic [3:0] led_val();
    return {p3A3, p3A2, p3A1, p3A0};
  endfunction

  task automatic push_ev(input int kind, input int e, input int c);
    ev_t ev;
    ev.kind = kind;
    ev.edge_no = e;
    ev.cnt = c;
    sb_q.push_back(ev);
  endtask

  task automatic model_reset();
    m_stable = 1'b0;
    m_run = 0;
    m_count = 0;
    m_long_pend = 1'b0;
    m_long_at = 0;
    m_held = 1'b0;
  endtask

  // Pressed-sample s enters the synchronizer on edge e; it is judged by the
  // debouncer on edge e+2, and any resulting FSM reaction is visible after edge e+3.
  task automatic model_sample(input bit s, input int e);
    int f;
    f = e + 2;
    if (s != m_stable) begin
      m_run++;
      if (m_run == DB_WIN) begin
        m_stable = s;
        m_run = 0;
        if (s) begin
          m_count = (m_count + 1) % 16;
          push_ev(K_PRESS, f + 1, m_count);
          m_long_pend = 1'b1;
          m_long_at = f + 1 + LONG_WIN;
        end else begin
          m_long_pend = 1'b0;
          if (m_held) begin
            push_ev(K_FALL, f + 1, m_count);
            m_held = 1'b0;
          end
        end
      end
    end else begin
      m_run = 0;
    end
    // Long strobe only if the level was still pressed through edge m_long_at-1.
    if (m_long_pend && f == m_long_at - 1) begin
      push_ev(K_LONG, m_long_at, m_count);
      m_long_pend = 1'b0;
      m_held = 1'b1;
    end
  endtask

  // Drive one pin level for the next posedge; called at a negedge, returns at the next.
  task automatic step(input logic val);
    p3B2 = val;
    model_sample(~val, cyc + 1);
    @(negedge pG0);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (led_val() != 4'd0 || press_pulse || long_pulse || held) begin
      fails++;
      $display("FAIL %s: got led=%b press=%b long=%b held=%b, want all 0",
               name, led_val(), press_pulse, long_pulse, held);
    end
  endtask

  task automatic apply_reset();
    pG1 = 1'b1;
    sb_q.delete();
    model_reset();
    @(negedge pG0);
    @(negedge pG0);
    check_zero("reset_hold");
    pG1 = 1'b0;
  endtask

  // Monitor: compares the event the DUT shows this cycle with the scoreboard head.
  always @(negedge pG0) begin
    int got_kind;
    int want_kind;
    bit have_exp;
    ev_t ev;
    if (pG1) begin
      exp_count = 0;
      held_prev = 1'b0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].edge_no < cyc) begin
        vectors++;
        fails++;
        $display("FAIL missed_event: kind %0d due edge %0d not seen (now edge %0d)",
                 sb_q[0].kind, sb_q[0].edge_no, cyc);
        void'(sb_q.pop_front());
      end
      have_exp = (sb_q.size() > 0) && (sb_q[0].edge_no == cyc);
      if (have_exp) ev = sb_q.pop_front();
      want_kind = have_exp ? ev.kind : K_NONE;
      if (press_pulse && long_pulse) got_kind = K_BOTH;
      else if (press_pulse)          got_kind = K_PRESS;
      else if (long_pulse)           got_kind = K_LONG;
      else if (held_prev && !held)   got_kind = K_FALL;
      else                           got_kind = K_NONE;
      if (have_exp || got_kind != K_NONE) begin
        vectors++;
        if (got_kind != want_kind) begin
          fails++;
          $display("FAIL event_kind @edge %0d: got %0d, want %0d", cyc, got_kind, want_kind);
        end
        if (want_kind == K_PRESS) exp_count = ev.cnt;
        if (want_kind == K_LONG) begin
          vectors++;
          if (held !== 1'b1) begin
            fails++;
            $display("FAIL held_on_long @edge %0d: got %b, want 1", cyc, held);
          end
        end
      end
      vectors++;
      if (led_val() != exp_count[3:0]) begin
        fails++;
        $display("FAIL led_count @edge %0d: got %0d, want %0d", cyc, led_val(), exp_count);
      end
      if (press_pulse) press_seen++;
      held_prev = held;
    end
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timed out");
  end

  initial begin
    int base;
    pG1 = 1'b1;
    p3B2 = 1'b1;
    model_reset();
    @(negedge pG0);
    #2 check_zero("reset_async_start");
    @(negedge pG0);
    @(negedge pG0);
    check_zero("reset_state");
    pG1 = 1'b0;

    // Idle, then a clean press and release.
    repeat (20) step(1'b1);
    check_zero("idle_outputs");
    repeat (30) step(1'b0);
    repeat (20) step(1'b1);

    // Glitches shorter than the debounce window.
    repeat (3) step(1'b0);
    repeat (10) step(1'b1);
    repeat (3) step(1'b0);
    step(1'b1);
    repeat (3) step(1'b0);
    repeat (10) step(1'b1);

    // Long hold, then release.
    repeat (20) step(1'b0);
    repeat (20) step(1'b1);

    // Sixteen presses from a cleared count wrap back to zero.
    apply_reset();
    base = press_seen;
    for (int i = 0; i < 16; i++) begin
      repeat (8) step(1'b0);
      repeat (8) step(1'b1);
    end
    vectors++;
    if (press_seen - base != 16 || led_val() != 4'd0) begin
      fails++;
      $display("FAIL wrap16: got %0d strobes led=%0d, want 16 strobes led=0",
               press_seen - base, led_val());
    end

    // Random pin activity.
    for (int i = 0; i < 60; i++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 20);
      repeat (len) step(lvl);
    end
    repeat (20) step(1'b1);

    // Reset between clock edges in the middle of a long hold.
    repeat (16) step(1'b0);
    #2 pG1 = 1'b1;
    #2 check_zero("reset_mid_hold");
    sb_q.delete();
    model_reset();
    @(negedge pG0);
    @(negedge pG0);
    pG1 = 1'b0;
    repeat (7) step(1'b0);
    vectors++;
    if (press_pulse !== 1'b1 || led_val() != 4'd1) begin
      fails++;
      $display("FAIL repress_after_reset: got press=%b led=%0d, want press=1 led=1",
               press_pulse, led_val());
    end
    repeat (10) step(1'b0);
    repeat (30) step(1'b1);

    @(negedge pG0);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
